jtcop_objdma: RTL
=================

# jtcop_objdma

Object-RAM DMA controller for the Data East 16-bit boards. On the per-frame copy strobe (the decoder's `obj_copy`, active at VBLANK start) it copies the CPU-side object RAM into the private sprite buffer read by the object engine. It shares the object RAM read port with the 68000: CPU accesses (`obj_cs`) always win, and the DMA steals every idle cycle.

## Interface
Parameters:
- `AW`, 10: object RAM address width in 16-bit words; one copy moves 2**AW words.

Ports:
- `rst`  in  1  asynchronous, active-high reset
- `clk`  in  1  system clock
- `copy`  in  1  start strobe; sampled every clock, acted on only in IDLE
- `cpu_cs`  in  1  CPU is using the object RAM port this cycle (`obj_cs`)
- `ram_addr`  out  AW  DMA read address to the object RAM port mux
- `dma_sel`  out  1  1 = RAM port takes `ram_addr` this cycle (read issued)
- `ram_dout`  in  16  object RAM read data, valid one clock after the read is issued
- `buf_addr`  out  AW  sprite buffer write address
- `buf_din`  out  16  sprite buffer write data
- `buf_we`  out  1  sprite buffer write enable
- `busy`  out  1  copy in progress
- `done`  out  1  one-cycle pulse with the final buffer write

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: `busy`=0, `dma_sel`=0. If `copy`=1: read counter ← 0, go to RUN.
- RUN: `busy`=1. `dma_sel` = !`cpu_cs` (combinational). When `dma_sel`=1: read issued at `ram_addr` = counter; counter increments. If the issued address is 2**AW−1, go to FLUSH.
- When `cpu_cs`=1 in RUN: no read, counter holds, no stall of writes already in the pipe.
- Write pipeline: one register stage. A read issued in cycle n produces `buf_we`=1 in cycle n+1 with `buf_addr` = address issued in n and `buf_din` = `ram_dout` sampled in n+1 (passed combinationally from `ram_dout`, address registered).
- FLUSH: the final write occurs; `done`=1 this cycle; next state IDLE.
- `copy` while `busy`=1 is ignored (no queueing, no restart).
- `copy` held high across the end of a copy starts a new copy on the first IDLE cycle.
- Addresses only ever increase 0 … 2**AW−1; read counter is AW+1 bits internally so wrap is impossible; every address written exactly once per copy, in order.

## Timing
- Reset (async, any time incl. mid-copy): state IDLE, counter 0, `ram_addr`=0, `dma_sel`=0, `buf_addr`=0, `buf_din` follows `ram_dout` but `buf_we`=0, `busy`=0, `done`=0. Interrupted copy is abandoned, never resumed.
- `copy` high in cycle 0 (IDLE) → RUN and `busy`=1 from cycle 1; first possible read in cycle 1, first `buf_we` in cycle 2.
- Uncontended copy: reads cycles 1…2**AW, writes cycles 2…2**AW+1, `done` in cycle 2**AW+1, `busy` low from cycle 2**AW+2. Total 2**AW+1 busy cycles.
- Each cycle of `cpu_cs`=1 during RUN adds exactly one cycle to the copy. `cpu_cs` in FLUSH or IDLE has no effect.
- `dma_sel` and `cpu_cs` never both 1.
- `buf_we` is never asserted in IDLE except the FLUSH-to-IDLE hand-off cycle is FLUSH itself; at most one `buf_we` per clock.

## Test plan
- AW=4, `copy` pulse, `cpu_cs`=0, RAM word i = 16'hA000+i → 16 writes, `buf_addr` 0…15 with data A000…A00F on consecutive cycles 2…17, `done` at cycle 17, `busy` low at 18.
- Same, `cpu_cs`=1 on cycles 3,4 and 10 → `dma_sel`=0 those cycles, no duplicated/skipped address, `done` at cycle 20.
- `cpu_cs` held 1 for 50 cycles after start → no reads, `busy`=1 throughout, copy completes 50 cycles late with correct data.
- Second `copy` pulse mid-copy (cycle 8) → ignored; exactly 16 writes, one `done`.
- `rst` asserted at cycle 9 of a copy → all outputs zero immediately; after release with no `copy`, no `buf_we` for 100 cycles; new `copy` performs a full fresh copy from address 0.
- `copy` held high continuously → back-to-back copies, each 16 writes, one IDLE cycle between `done` and next `busy`.

Source files
------------

// File: rtl/jtcop_objdma.sv
// jtcop_objdma
// ------------------------------------------------------------------------
// Object-RAM DMA controller. On the per-frame copy strobe (taken at VBLANK
// start) it copies the whole CPU-side object RAM into the private sprite
// buffer that the object engine reads. The object RAM read port is shared
// with the CPU. A CPU access always wins, and the DMA uses every cycle in
// which the CPU is not accessing the RAM.
//
// Parameters
//   AW        object RAM address width in 16-bit words (one copy = 2**AW words)
//
// Ports
//   rst       asynchronous, active-high reset
//   clk       system clock
//   copy      start strobe; only acted on while idle
//   cpu_cs    CPU owns the object RAM port this cycle
//   ram_addr  DMA read address presented to the RAM port mux
//   dma_sel   RAM port takes ram_addr this cycle (a read is issued)
//   ram_dout  object RAM read data, valid one clock after the read
//   buf_addr  sprite buffer write address
//   buf_din   sprite buffer write data (ram_dout passed straight through)
//   buf_we    sprite buffer write enable
//   busy      copy in progress
//   done      one-cycle pulse that coincides with the final buffer write
// ------------------------------------------------------------------------
module jtcop_objdma #(
    parameter int AW = 10
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          copy,
    input  logic          cpu_cs,
    output logic [AW-1:0] ram_addr,
    output logic          dma_sel,
    input  logic [15:0]   ram_dout,
    output logic [AW-1:0] buf_addr,
    output logic [15:0]   buf_din,
    output logic          buf_we,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Address of the last word of the RAM, widened to the counter width.
    // The counter carries one extra bit so it can never wrap back onto
    // address 0 within a copy.
    localparam logic [AW:0] LAST_ADDR = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0] CNT_ONE   = {{AW{1'b0}}, 1'b1};

    state_t        state_reg, state_next;
    logic [AW:0]   cnt_reg, cnt_next;
    logic [AW-1:0] waddr_reg, waddr_next;
    logic          we_reg, we_next;

    // ------------------------------------------------------------------
    // State and pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            waddr_reg <= '0;
            we_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            waddr_reg <= waddr_next;
            we_reg    <= we_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        waddr_next = waddr_reg;
        we_next    = 1'b0;
        dma_sel    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_reg)
            IDLE: begin
                // A strobe that arrives while busy is simply lost; a strobe
                // held high restarts on the first idle cycle.
                if (copy) begin
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end

            RUN: begin
                busy    = 1'b1;
                dma_sel = !cpu_cs;
                if (!cpu_cs) begin
                    // Read issued now; its data is written next cycle at
                    // the address captured here.
                    cnt_next   = cnt_reg + CNT_ONE;
                    we_next    = 1'b1;
                    waddr_next = cnt_reg[AW-1:0];
                    if (cnt_reg == LAST_ADDR) begin
                        state_next = FLUSH;
                    end
                end
                // A CPU cycle holds the counter but never stalls the write
                // that is already in the pipe.
            end

            FLUSH: begin
                // The last read was issued in the previous cycle, so the
                // final buffer write happens here.
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ram_addr = cnt_reg[AW-1:0];
    assign buf_addr = waddr_reg;
    assign buf_we   = we_reg;
    // RAM data arrives one clock after the read, exactly in step with the
    // registered write address, so it needs no register of its own.
    assign buf_din  = ram_dout;

endmodule
